// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle sequencer driving one-hot stage enables for the 16-bit RISC core
module core_seq_ctrl #(
   parameter logic [3:0] LOAD_OP  = 4'b1000,
   parameter logic [3:0] STORE_OP = 4'b1001,
   parameter logic [3:0] HALT_OP  = 4'b1111,
   parameter logic [7:0] TIMEOUT  = 8'd15
) (
   input  logic        I_Clk,
   input  logic        I_Rst_n,
   input  logic        I_Run,
   input  logic [4:0]  I_Aluop,
   input  logic        I_Regwe,
   input  logic        I_Mem_Ack,
   output logic        O_En_Fetch,
   output logic        O_En_Dec,
   output logic        O_En_Rreg,
   output logic        O_En_Alu,
   output logic        O_En_Mem,
   output logic        O_En_Regwr,
   output logic        O_Mem_Req,
   output logic        O_Mem_We,
   output logic        O_Busy,
   output logic        O_Halted,
   output logic        O_Fault,
   output logic [15:0] O_Retired
);
   typedef enum logic [3:0] {
      S_IDLE, S_FETCH, S_DEC, S_RREG, S_ALU, S_MEM, S_WB, S_HALT, S_FAULT
   } state_t;
   state_t      r_state, w_next;
   logic [7:0]  r_wait;
   logic [3:0]  r_op;
   logic [15:0] r_retired;
   logic        w_retire;
   logic        w_timeout;
   logic [3:0]  w_opc;
   logic        w_unused;
   assign w_opc     = I_Aluop[4:1];
   assign w_timeout = r_wait == TIMEOUT - 8'd1;
   assign w_unused  = I_Aluop[0];
   assign O_Retired = r_retired;
   // state register
   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) r_state <= S_IDLE;
      else r_state <= w_next;
   end
   // next-state and retire decision; I_Run only matters at IDLE, HALT and instruction boundaries
   always_comb begin
      w_next   = r_state;
      w_retire = 1'b0;
      case (r_state)
         S_IDLE:  w_next = I_Run ? S_FETCH : S_IDLE;
         S_FETCH: w_next = I_Mem_Ack ? S_DEC : (w_timeout ? S_FAULT : S_FETCH);
         S_DEC:   w_next = S_RREG;
         S_RREG:  w_next = S_ALU;
         S_ALU: begin
            if (w_opc == HALT_OP) begin
               w_next   = S_HALT;
               w_retire = 1'b1;
            end else if (w_opc == LOAD_OP || w_opc == STORE_OP) begin
               w_next = S_MEM;
            end else if (I_Regwe) begin
               w_next = S_WB;
            end else begin
               w_next   = I_Run ? S_FETCH : S_IDLE;
               w_retire = 1'b1;
            end
         end
         S_MEM: begin
            if (I_Mem_Ack && r_op == STORE_OP) begin
               w_next   = I_Run ? S_FETCH : S_IDLE;
               w_retire = 1'b1;
            end else if (I_Mem_Ack) begin
               w_next = S_WB;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end
         end
         S_WB: begin
            w_next   = I_Run ? S_FETCH : S_IDLE;
            w_retire = 1'b1;
         end
         S_HALT:  w_next = I_Run ? S_HALT : S_IDLE;
         S_FAULT: w_next = S_FAULT;
         default: w_next = S_IDLE;
      endcase
   end
   // Moore decode of stage enables and status
   always_comb begin
      O_En_Fetch = r_state == S_FETCH;
      O_En_Dec   = r_state == S_DEC;
      O_En_Rreg  = r_state == S_RREG;
      O_En_Alu   = r_state == S_ALU;
      O_En_Mem   = r_state == S_MEM;
      O_En_Regwr = r_state == S_WB;
      O_Mem_Req  = r_state == S_FETCH || r_state == S_MEM;
      O_Mem_We   = r_state == S_MEM && r_op == STORE_OP;
      O_Busy     = !(r_state == S_IDLE || r_state == S_HALT || r_state == S_FAULT);
      O_Halted   = r_state == S_HALT;
      O_Fault    = r_state == S_FAULT;
   end
   // handshake wait counter: cleared on entering FETCH/MEM, counts un-acked request cycles
   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) r_wait <= 8'd0;
      else if (w_next != r_state && (w_next == S_FETCH || w_next == S_MEM)) r_wait <= 8'd0;
      else if ((r_state == S_FETCH || r_state == S_MEM) && !I_Mem_Ack) r_wait <= r_wait + 8'd1;
   end
   // opcode captured in ALU so MEM knows load vs store after the decoder moves on
   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) r_op <= 4'd0;
      else if (r_state == S_ALU) r_op <= w_opc;
   end
   // retired-instruction counter, wraps naturally
   always_ff @(posedge I_Clk or negedge I_Rst_n) begin
      if (!I_Rst_n) r_retired <= 16'd0;
      else if (w_retire) r_retired <= r_retired + 16'd1;
   end
endmodule
